// File: rtl/execute_memory_register.sv
// Execute-to-Memory pipeline latch.
// Captures the datapath and control of the instruction leaving EX, owns the
// architectural {Z, V, N} flag register, resolves the writeback-to-store-data
// bypass, and freezes completely once a valid halt has been latched.
module execute_memory_register (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        flush,
    input  logic        valid_ex,
    input  logic [3:0]  opcode_ex,
    input  logic [15:0] alu_out_ex,
    input  logic [15:0] rt_data_ex,
    input  logic [3:0]  rt_addr_ex,
    input  logic [15:0] next_pc_ex,
    input  logic [3:0]  write_reg_ex,
    input  logic        reg_write_ex,
    input  logic        mem_read_ex,
    input  logic        mem_write_ex,
    input  logic        mem_to_reg_ex,
    input  logic        halt_ex,
    input  logic        alu_z,
    input  logic        alu_v,
    input  logic        alu_n,
    input  logic        reg_write_wb,
    input  logic [3:0]  write_reg_wb,
    input  logic [15:0] wb_data,
    output logic [15:0] alu_out_xm,
    output logic [15:0] store_data_xm,
    output logic [15:0] next_pc_xm,
    output logic [3:0]  opcode_xm,
    output logic [3:0]  write_reg_xm,
    output logic        reg_write_xm,
    output logic        mem_read_xm,
    output logic        mem_write_xm,
    output logic        mem_to_reg_xm,
    output logic        halt_xm,
    output logic        valid_xm,
    output logic [2:0]  flags
);

    // Opcodes that touch the flag register.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    // Per-edge actions derived from the state and the stage controls.
    logic        advance;
    logic        load_bubble;
    logic        flag_z_we;
    logic        flag_vn_we;

    // Store-data bypass.
    logic        store_bypass;
    logic [15:0] store_data_next;

    // Latched contents.
    logic [15:0] alu_out_reg;
    logic [15:0] store_data_reg;
    logic [15:0] next_pc_reg;
    logic [3:0]  opcode_reg;
    logic [3:0]  write_reg_reg;
    logic        reg_write_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic        mem_to_reg_reg;
    logic        halt_reg;
    logic        valid_reg;
    logic [2:0]  flags_reg;

    // Flag bit order is {Z, V, N}; V and N share one write enable.
    logic [2:0]  flag_we;
    logic [2:0]  flag_in;

    // State register: RUN / HALTED, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: a valid halt that actually advances into the latch freezes it.
    always_comb begin
        state_next = state_reg;
        if (advance && valid_ex && halt_ex) begin
            state_next = HALTED;
        end
    end

    // Action decode: freeze beats flush, flush beats enable, otherwise hold.
    always_comb begin
        advance     = 1'b0;
        load_bubble = 1'b0;
        if (state_reg == RUN) begin
            if (flush) begin
                load_bubble = 1'b1;
            end else if (enable) begin
                advance = 1'b1;
            end
        end
        flag_vn_we = advance && valid_ex &&
                     ((opcode_ex == OP_ADD) || (opcode_ex == OP_SUB));
        flag_z_we  = advance && valid_ex &&
                     ((opcode_ex == OP_ADD) || (opcode_ex == OP_SUB) ||
                      (opcode_ex == OP_XOR) || (opcode_ex == OP_SLL) ||
                      (opcode_ex == OP_SRA) || (opcode_ex == OP_ROR));
    end

    // A store whose data register is being written back this cycle takes the
    // writeback value; register 0 is never forwarded.
    always_comb begin
        store_bypass    = mem_write_ex && reg_write_wb &&
                          (write_reg_wb == rt_addr_ex) &&
                          (write_reg_wb != 4'd0);
        store_data_next = store_bypass ? wb_data : rt_data_ex;
    end

    // Pipeline contents: bubble clears everything, advance captures EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_reg    <= 16'd0;
            store_data_reg <= 16'd0;
            next_pc_reg    <= 16'd0;
            opcode_reg     <= 4'd0;
            write_reg_reg  <= 4'd0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            halt_reg       <= 1'b0;
            valid_reg      <= 1'b0;
        end else if (load_bubble) begin
            alu_out_reg    <= 16'd0;
            store_data_reg <= 16'd0;
            next_pc_reg    <= 16'd0;
            opcode_reg     <= 4'd0;
            write_reg_reg  <= 4'd0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            halt_reg       <= 1'b0;
            valid_reg      <= 1'b0;
        end else if (advance) begin
            alu_out_reg    <= alu_out_ex;
            store_data_reg <= store_data_next;
            next_pc_reg    <= next_pc_ex;
            opcode_reg     <= opcode_ex;
            write_reg_reg  <= write_reg_ex;
            reg_write_reg  <= reg_write_ex;
            mem_read_reg   <= mem_read_ex;
            mem_write_reg  <= mem_write_ex;
            mem_to_reg_reg <= mem_to_reg_ex;
            halt_reg       <= halt_ex;
            valid_reg      <= valid_ex;
        end
    end

    assign flag_we = {flag_z_we, flag_vn_we, flag_vn_we};
    assign flag_in = {alu_z, alu_v, alu_n};

    // One flop per flag bit, each loading only when its opcode class updates it.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    flags_reg[gi] <= 1'b0;
                end else if (flag_we[gi]) begin
                    flags_reg[gi] <= flag_in[gi];
                end
            end
        end
    endgenerate

    assign alu_out_xm    = alu_out_reg;
    assign store_data_xm = store_data_reg;
    assign next_pc_xm    = next_pc_reg;
    assign opcode_xm     = opcode_reg;
    assign write_reg_xm  = write_reg_reg;
    assign reg_write_xm  = reg_write_reg;
    assign mem_read_xm   = mem_read_reg;
    assign mem_write_xm  = mem_write_reg;
    assign mem_to_reg_xm = mem_to_reg_reg;
    assign halt_xm       = halt_reg;
    assign valid_xm      = valid_reg;
    assign flags         = flags_reg;

endmodule

// File: tb/tb_execute_memory_register.sv
// Bench for execute_memory_register: directed vector table, hand-written
// reset/halt/flush sequences, then randomized traffic against a reference model.
module tb_execute_memory_register;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, flush, valid_ex;
    logic [3:0]  opcode_ex, rt_addr_ex, write_reg_ex, write_reg_wb;
    logic [15:0] alu_out_ex, rt_data_ex, next_pc_ex, wb_data;
    logic        reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex, halt_ex;
    logic        alu_z, alu_v, alu_n, reg_write_wb;
    logic [15:0] alu_out_xm, store_data_xm, next_pc_xm;
    logic [3:0]  opcode_xm, write_reg_xm;
    logic        reg_write_xm, mem_read_xm, mem_write_xm, mem_to_reg_xm, halt_xm, valid_xm;
    logic [2:0]  flags;

    always #5 clk = ~clk;

    execute_memory_register dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush), .valid_ex(valid_ex),
        .opcode_ex(opcode_ex), .alu_out_ex(alu_out_ex), .rt_data_ex(rt_data_ex),
        .rt_addr_ex(rt_addr_ex), .next_pc_ex(next_pc_ex), .write_reg_ex(write_reg_ex),
        .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .mem_to_reg_ex(mem_to_reg_ex), .halt_ex(halt_ex), .alu_z(alu_z), .alu_v(alu_v),
        .alu_n(alu_n), .reg_write_wb(reg_write_wb), .write_reg_wb(write_reg_wb),
        .wb_data(wb_data), .alu_out_xm(alu_out_xm), .store_data_xm(store_data_xm),
        .next_pc_xm(next_pc_xm), .opcode_xm(opcode_xm), .write_reg_xm(write_reg_xm),
        .reg_write_xm(reg_write_xm), .mem_read_xm(mem_read_xm), .mem_write_xm(mem_write_xm),
        .mem_to_reg_xm(mem_to_reg_xm), .halt_xm(halt_xm), .valid_xm(valid_xm), .flags(flags)
    );

    typedef struct packed {
        logic [15:0] alu, st, npc;
        logic [3:0]  op, wr;
        logic        rw, mr, mw, m2r, hlt, vld;
        logic [2:0]  flg;
    } out_t;

    out_t dut_o;
    assign dut_o = {alu_out_xm, store_data_xm, next_pc_xm, opcode_xm, write_reg_xm,
                    reg_write_xm, mem_read_xm, mem_write_xm, mem_to_reg_xm, halt_xm,
                    valid_xm, flags};

    // Reference state: what the Memory stage should be holding, and whether frozen.
    out_t m;
    logic m_halted;
    int   vectors = 0;
    int   miscompares = 0;

    // Spec-level next-state computation from the current inputs.
    task automatic model_next(output out_t n, output logic nh);
        n  = m;
        nh = m_halted;
        if (!m_halted) begin
            if (flush) begin
                n = '0;
                n.flg = m.flg;
            end else if (enable) begin
                n.alu = alu_out_ex;
                n.st  = (mem_write_ex && reg_write_wb && write_reg_wb == rt_addr_ex &&
                         write_reg_wb != 4'd0) ? wb_data : rt_data_ex;
                n.npc = next_pc_ex;  n.op = opcode_ex;    n.wr  = write_reg_ex;
                n.rw  = reg_write_ex; n.mr = mem_read_ex; n.mw  = mem_write_ex;
                n.m2r = mem_to_reg_ex; n.hlt = halt_ex;   n.vld = valid_ex;
                if (valid_ex) begin
                    if (opcode_ex inside {4'h0, 4'h1})
                        n.flg = {alu_z, alu_v, alu_n};
                    else if (opcode_ex inside {4'h2, 4'h4, 4'h5, 4'h6})
                        n.flg[2] = alu_z;
                end
                if (valid_ex && halt_ex) nh = 1'b1;
            end
        end
    endtask

    task automatic check(input string name);
        vectors++;
        if (dut_o !== m) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, dut_o, m);
        end else begin
            $display("ok   %s: %h", name, dut_o);
        end
    endtask

    // Advance one clock with the current inputs and compare against the model.
    task automatic step(input string name);
        out_t n;
        logic nh;
        model_next(n, nh);
        @(posedge clk);
        m = n;
        m_halted = nh;
        #1;
        check(name);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse(input string name);
        #2;
        rst = 1'b1;
        #1;
        m = '0;
        m_halted = 1'b0;
        check(name);
        rst = 1'b0;
    endtask

    task automatic drive(input logic en, input logic fl, input logic vld, input logic [3:0] op,
                         input logic [15:0] alu, input logic [15:0] rtd, input logic [3:0] rta,
                         input logic mw, input logic rwb, input logic [3:0] wrwb,
                         input logic [15:0] wbd, input logic z, input logic v, input logic n,
                         input logic hlt);
        enable = en; flush = fl; valid_ex = vld; opcode_ex = op; alu_out_ex = alu;
        rt_data_ex = rtd; rt_addr_ex = rta; mem_write_ex = mw; reg_write_wb = rwb;
        write_reg_wb = wrwb; wb_data = wbd; alu_z = z; alu_v = v; alu_n = n; halt_ex = hlt;
        next_pc_ex = alu ^ 16'h5A5A; write_reg_ex = 4'd2; reg_write_ex = vld;
        mem_read_ex = 1'b0; mem_to_reg_ex = 1'b0;
    endtask

    typedef struct {
        logic en, fl, vld; logic [3:0] op; logic [15:0] alu, rtd; logic [3:0] rta;
        logic mw, rwb; logic [3:0] wrwb; logic [15:0] wbd; logic z, v, n, hlt;
        logic e_vld; logic [15:0] e_alu, e_st; logic [2:0] e_flg;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{1'b1,1'b0,1'b1,4'h0,16'h0000,16'h2222,4'h3,1'b0,1'b0,4'h0,16'h0000,1'b1,1'b1,1'b0,1'b0, 1'b1,16'h0000,16'h2222,3'b110};
        tbl[1]  = '{1'b1,1'b0,1'b1,4'h2,16'h00FF,16'h3333,4'h3,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b1,1'b0, 1'b1,16'h00FF,16'h3333,3'b010};
        tbl[2]  = '{1'b0,1'b0,1'b1,4'h0,16'hAAAA,16'h5555,4'h3,1'b0,1'b0,4'h0,16'h0000,1'b1,1'b1,1'b1,1'b0, 1'b1,16'h00FF,16'h3333,3'b010};
        tbl[3]  = '{1'b0,1'b0,1'b1,4'h1,16'hBBBB,16'h5555,4'h3,1'b0,1'b0,4'h0,16'h0000,1'b1,1'b1,1'b1,1'b0, 1'b1,16'h00FF,16'h3333,3'b010};
        tbl[4]  = '{1'b0,1'b0,1'b1,4'h2,16'hCCCC,16'h5555,4'h3,1'b0,1'b0,4'h0,16'h0000,1'b1,1'b1,1'b1,1'b0, 1'b1,16'h00FF,16'h3333,3'b010};
        tbl[5]  = '{1'b0,1'b1,1'b1,4'h0,16'hDDDD,16'h6666,4'h3,1'b0,1'b0,4'h0,16'h0000,1'b1,1'b1,1'b1,1'b0, 1'b0,16'h0000,16'h0000,3'b010};
        tbl[6]  = '{1'b1,1'b0,1'b0,4'h0,16'h1234,16'h4444,4'h3,1'b0,1'b0,4'h0,16'h0000,1'b1,1'b1,1'b1,1'b0, 1'b0,16'h1234,16'h4444,3'b010};
        tbl[7]  = '{1'b1,1'b0,1'b1,4'h8,16'h0040,16'h1111,4'h5,1'b1,1'b1,4'h5,16'hBEEF,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0040,16'hBEEF,3'b010};
        tbl[8]  = '{1'b1,1'b0,1'b1,4'h8,16'h0042,16'h1111,4'h0,1'b1,1'b1,4'h0,16'hBEEF,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0042,16'h1111,3'b010};
        tbl[9]  = '{1'b1,1'b0,1'b1,4'h8,16'h0044,16'h1111,4'h5,1'b1,1'b1,4'h6,16'hBEEF,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0044,16'h1111,3'b010};
        tbl[10] = '{1'b1,1'b0,1'b1,4'h1,16'h8000,16'h0000,4'h0,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b1,1'b1,1'b0, 1'b1,16'h8000,16'h0000,3'b011};
        tbl[11] = '{1'b1,1'b0,1'b1,4'h4,16'h0000,16'h0000,4'h0,1'b0,1'b0,4'h0,16'h0000,1'b1,1'b0,1'b0,1'b0, 1'b1,16'h0000,16'h0000,3'b111};
        tbl[12] = '{1'b1,1'b0,1'b1,4'h3,16'h0001,16'h0000,4'h0,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0001,16'h0000,3'b111};
        tbl[13] = '{1'b1,1'b0,1'b1,4'h0,16'h0002,16'h7777,4'h5,1'b0,1'b1,4'h5,16'hBEEF,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0002,16'h7777,3'b000};
        tbl[14] = '{1'b1,1'b0,1'b1,4'h6,16'h0003,16'h0000,4'h0,1'b0,1'b0,4'h0,16'h0000,1'b1,1'b1,1'b1,1'b0, 1'b1,16'h0003,16'h0000,3'b100};
        tbl[15] = '{1'b1,1'b0,1'b1,4'h5,16'h0004,16'h0000,4'h0,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b1,1'b1,1'b0, 1'b1,16'h0004,16'h0000,3'b000};

        // Reset state.
        rst = 1'b1;
        drive(1'b0,1'b0,1'b0,4'h0,16'h0,16'h0,4'h0,1'b0,1'b0,4'h0,16'h0,1'b0,1'b0,1'b0,1'b0);
        m = '0;
        m_halted = 1'b0;
        #3;
        check("reset_state");
        #4;
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].en, tbl[i].fl, tbl[i].vld, tbl[i].op, tbl[i].alu, tbl[i].rtd,
                  tbl[i].rta, tbl[i].mw, tbl[i].rwb, tbl[i].wrwb, tbl[i].wbd,
                  tbl[i].z, tbl[i].v, tbl[i].n, tbl[i].hlt);
            step($sformatf("table_model_%0d", i));
            vectors++;
            if ({valid_xm, alu_out_xm, store_data_xm, flags} !==
                {tbl[i].e_vld, tbl[i].e_alu, tbl[i].e_st, tbl[i].e_flg}) begin
                miscompares++;
                $display("FAIL table_%0d: got vld=%b alu=%h st=%h flg=%b expected vld=%b alu=%h st=%h flg=%b",
                         i, valid_xm, alu_out_xm, store_data_xm, flags,
                         tbl[i].e_vld, tbl[i].e_alu, tbl[i].e_st, tbl[i].e_flg);
            end else begin
                $display("ok   table_%0d", i);
            end
        end

        // Reset mid-run with a valid ADD latched, then resume.
        drive(1'b1,1'b0,1'b1,4'h0,16'h1357,16'h2468,4'h1,1'b0,1'b0,4'h0,16'h0,1'b0,1'b1,1'b1,1'b0);
        step("add_before_reset");
        reset_pulse("async_reset_mid_run");
        drive(1'b1,1'b0,1'b1,4'h1,16'h0F0F,16'h1111,4'h1,1'b0,1'b0,4'h0,16'h0,1'b0,1'b0,1'b1,1'b0);
        step("first_after_reset");

        // Flush together with a valid halt: bubble wins, state stays RUN.
        drive(1'b1,1'b1,1'b1,4'hF,16'h9999,16'h0,4'h0,1'b0,1'b0,4'h0,16'h0,1'b1,1'b1,1'b1,1'b1);
        step("flush_beats_halt");
        drive(1'b1,1'b0,1'b1,4'h0,16'h4321,16'h0,4'h0,1'b0,1'b0,4'h0,16'h0,1'b1,1'b0,1'b0,1'b0);
        step("runs_after_flushed_halt");

        // Halt freeze.
        drive(1'b1,1'b0,1'b1,4'hF,16'h00AA,16'h00BB,4'h2,1'b0,1'b0,4'h0,16'h0,1'b0,1'b1,1'b1,1'b1);
        step("halt_latch");
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i[0], 1'b1, 4'h0, 16'($urandom), 16'($urandom), 4'h1, 1'b0, 1'b0,
                  4'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
            step($sformatf("halt_frozen_%0d", i));
            vectors++;
            if (halt_xm !== 1'b1 || valid_xm !== 1'b1) begin
                miscompares++;
                $display("FAIL halt_flag_%0d: got halt=%b valid=%b expected 1 1", i, halt_xm, valid_xm);
            end
        end
        reset_pulse("reset_exits_halt");
        drive(1'b1,1'b0,1'b1,4'h2,16'h0777,16'h0,4'h0,1'b0,1'b0,4'h0,16'h0,1'b1,1'b1,1'b1,1'b0);
        step("advance_after_halt_reset");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) begin
                reset_pulse($sformatf("rand_reset_%0d", i));
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                  4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)),
                  16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 15) == 0);
            write_reg_ex  = 4'($urandom);
            reg_write_ex  = 1'($urandom);
            mem_read_ex   = 1'($urandom);
            mem_to_reg_ex = 1'($urandom);
            next_pc_ex    = 16'($urandom);
            step($sformatf("rand_%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/execute_memory_register.md
# execute_memory_register

Pipeline latch between the Execute stage and the Memory stage. It captures the ALU result, store data, next PC, destination register and memory/writeback control for the instruction leaving the decode/execute latch. It also owns the architectural flag register (Z, V, N) and resolves the load-to-store store-data bypass from writeback. It supports stall (enable low), bubble insertion (flush) and halt freezing.

## Interface
- No parameters; datapath fixed at 16 bits, register addresses 4 bits.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  1 = latch advances; 0 = hold all contents (stall)
- flush  in  1  1 = load a bubble on this edge
- valid_ex  in  1  instruction in EX is real (not a bubble)
- opcode_ex  in  4  opcode of EX instruction
- alu_out_ex  in  16  ALU result / effective address
- rt_data_ex  in  16  store data after EX forwarding
- rt_addr_ex  in  4  source register of store data
- next_pc_ex  in  16  PC+2 of EX instruction (for PCS)
- write_reg_ex  in  4  destination register
- reg_write_ex, mem_read_ex, mem_write_ex, mem_to_reg_ex, halt_ex  in  1 each  control from DE latch
- alu_z, alu_v, alu_n  in  1 each  ALU flag results for EX instruction
- reg_write_wb  in  1  writeback stage will write a register
- write_reg_wb  in  4  writeback destination
- wb_data  in  16  writeback data
- alu_out_xm, store_data_xm, next_pc_xm  out  16 each  latched data
- opcode_xm, write_reg_xm  out  4 each  latched opcode / destination
- reg_write_xm, mem_read_xm, mem_write_xm, mem_to_reg_xm, halt_xm, valid_xm  out  1 each  latched control
- flags  out  3  {Z, V, N} architectural flag register

## Operation
- Update priority on each edge: rst > halted freeze > flush > enable > hold.
- Advance (enable=1, flush=0, not halted): every *_xm output takes its *_ex counterpart; valid_xm <= valid_ex.
- Store-data bypass: store_data_xm <= wb_data when mem_write_ex & reg_write_wb & (write_reg_wb == rt_addr_ex) & (write_reg_wb != 0); otherwise it takes rt_data_ex. The bypass is evaluated only on advancing edges.
- Flush (flush=1, not halted): valid_xm, reg_write_xm, mem_read_xm, mem_write_xm, mem_to_reg_xm and halt_xm are cleared; all 16-bit and 4-bit fields are cleared to 0. Flush overrides enable=0.
- Flag update occurs only on an advancing edge with valid_ex=1 and flush=0:
  - ADD 0000, SUB 0001: Z, V, N <= alu_z, alu_v, alu_n.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: Z <= alu_z; V and N hold.
  - All other opcodes, bubbles, flushed or stalled edges: flags hold.
- Halt freeze: once halt_xm=1 with valid_xm=1, the latch enters a HALTED state. In HALTED, all outputs and flags hold regardless of enable or flush. Only rst exits.
- States: RUN (normal) and HALTED. RUN moves to HALTED on the edge that latches a valid halt_ex. HALTED moves to RUN only on rst.

## Timing
- Latency is 1 cycle: inputs present before edge t appear on the *_xm outputs after edge t.
- flags are registered. The instruction in EX at cycle t+1 sees flags produced by the instruction latched at edge t. There is no combinational flag bypass.
- The bypass mux is combinational on the wb_* inputs and settles within the same cycle as the EX inputs.
- Reset (asynchronous, mid-operation included): all outputs go to 0, flags = 3'b000, state = RUN, immediately and independent of clk.
- Simultaneous flush and enable=0: a bubble is loaded.
- Simultaneous flush and halt_ex: the bubble wins, the halt is dropped and the state stays RUN.

## Test plan
- Reset mid-run: rst pulsed between edges while valid ADD is latched -> all outputs 0, flags=000 immediately; first edge after release latches next instruction.
- ADD producing 0x0000 with overflow (alu_z=1, alu_v=1, alu_n=0), then XOR with alu_z=0, alu_v=0, alu_n=1 -> flags 110 after ADD edge, then 010 after XOR edge (V held).
- Stall: enable=0 for 3 cycles while inputs change -> all *_xm and flags unchanged; flush=1 with enable=0 -> valid_xm=0, reg_write_xm=0, alu_out_xm=0.
- Bubble immunity: valid_ex=0, opcode_ex=0000, alu_z=1 -> flags unchanged, valid_xm=0.
- Store bypass: mem_write_ex=1, rt_addr_ex=5, rt_data_ex=0x1111, reg_write_wb=1, write_reg_wb=5, wb_data=0xBEEF -> store_data_xm=0xBEEF. Repeat with write_reg_wb=0, rt_addr_ex=0 -> 0x1111.
- Halt: valid HLT latched, then enable=1, flush=1 and new inputs applied for 4 cycles -> outputs and flags frozen, halt_xm=1. Assert rst -> all outputs 0, normal advance resumes.
